pmu_sequencer: RTL and testbench



---
 rtl/pmu_sequencer_pkg.sv | 36 +++
 rtl/pmu_sequencer_if.sv | 33 +++
 rtl/pmu_dcnt.sv | 42 ++++
 rtl/pmu_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_pmu_sequencer.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/pmu_sequencer_pkg.sv
// Shared mcu51 PMU definitions: sequencer state encodings, rst_cause bit
// positions, and the reset-kind encoding that selects which reset fan-out
// lines are asserted while the sequencer sits in RESET.
package pmu_sequencer_pkg;

    typedef enum logic [2:0] {
        PMU_RESET = 3'd0,
        PMU_RUN   = 3'd1,
        PMU_IDLE  = 3'd2,
        PMU_STOP  = 3'd3,
        PMU_WAKE  = 3'd4
    } pmu_state_e;

    localparam int CAUSE_POR = 0;
    localparam int CAUSE_WDT = 1;
    localparam int CAUSE_SW  = 2;

    typedef enum logic [1:0] {
        KIND_POR  = 2'd0,
        KIND_WDT  = 2'd1,
        KIND_SW   = 2'd2,
        KIND_BOTH = 2'd3
    } rst_kind_e;

    // Only called when at least one of wdts/srst is high.
    function automatic rst_kind_e kind_from_src(input logic wdts, input logic srst);
        if (wdts && srst) begin
            return KIND_BOTH;
        end
        if (wdts) begin
            return KIND_WDT;
        end
        return KIND_SW;
    endfunction

endpackage

// File: rtl/pmu_sequencer_if.sv
// PMU sequencer signal bundle.
//   master : requester side (reset sources, PCON requests, wakeup, cause clear)
//   slave  : the sequencer (clock enables, resume pulse, reset fan-out, status)
interface pmu_sequencer_if;

    logic       wdts;
    logic       srst;
    logic       idle_req;
    logic       stop_req;
    logic       int_req;
    logic       cause_clr;
    logic       clkcpu_en;
    logic       clkper_en;
    logic       cpu_resume;
    logic       rst_out;
    logic       rsttowdt;
    logic       rsttosrst;
    logic [2:0] pmu_state;
    logic [2:0] rst_cause;

    modport master (
        output wdts, srst, idle_req, stop_req, int_req, cause_clr,
        input  clkcpu_en, clkper_en, cpu_resume, rst_out, rsttowdt,
               rsttosrst, pmu_state, rst_cause
    );

    modport slave (
        input  wdts, srst, idle_req, stop_req, int_req, cause_clr,
        output clkcpu_en, clkper_en, cpu_resume, rst_out, rsttowdt,
               rsttosrst, pmu_state, rst_cause
    );

endinterface

// File: rtl/pmu_dcnt.sv
// Loadable saturating down-counter shared by the reset-stretch and
// oscillator-settle waits.
//   clk, rst  : clock, async active-high reset (counter goes to RST_VAL)
//   load      : load load_val (has priority over dec)
//   load_val  : value to load
//   dec       : decrement by one, holding at zero
//   zero      : counter currently equals zero
module pmu_dcnt #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pmu_sequencer.sv
// mcu51 power-management and reset sequencer. Sequences Idle/Stop entry and
// exit, waits for the oscillator to settle after Stop, stretches every reset
// source into a fixed-width reset and records the reset cause. All outputs
// are registered and reflect the state entered on the same edge.
//   clk  : free-running (ungated) system clock
//   rst  : async active-high hardware reset (power-on)
//   bus  : pmu_sequencer_if.slave - requests in, enables/resets/status out
//
// state | meaning
// RESET | reset fan-out asserted, clocks enabled, stretching the reset
// RUN   | normal operation, both clocks running
// IDLE  | CPU clock gated, peripherals running, waiting for int_req
// STOP  | all clocks gated, waiting for int_req
// WAKE  | clocks still gated while the oscillator settles
module pmu_sequencer
    import pmu_sequencer_pkg::*;
#(
    parameter int RST_HOLD = 16,
    parameter int WAKE_CYC = 256,
    parameter int CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    pmu_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYC - 1);

    pmu_state_e state_q, state_d;
    rst_kind_e  kind_q, kind_d;
    logic [2:0] cause_q, cause_d;
    logic       clkcpu_en_q, clkcpu_en_d;
    logic       clkper_en_q, clkper_en_d;
    logic       cpu_resume_q, cpu_resume_d;
    logic       rst_out_q, rst_out_d;
    logic       rsttowdt_q, rsttowdt_d;
    logic       rsttosrst_q, rsttosrst_d;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             cnt_zero;

    pmu_dcnt #(
        .CNT_W   (CNT_W),
        .RST_VAL (RST_LOAD)
    ) u_dcnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Next state and counter control.
    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        cpu_resume_d = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = RST_LOAD;
        cnt_dec      = 1'b0;

        if (bus.wdts || bus.srst) begin
            // A source still high keeps reloading, so the stretch is
            // measured from the last source cycle.
            state_d  = PMU_RESET;
            kind_d   = kind_from_src(bus.wdts, bus.srst);
            cnt_load = 1'b1;
        end else begin
            unique case (state_q)
                PMU_RESET: begin
                    if (cnt_zero) begin
                        state_d = PMU_RUN;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                PMU_RUN: begin
                    // A pending wakeup cancels a low-power request outright.
                    if (!bus.int_req) begin
                        if (bus.stop_req) begin
                            state_d = PMU_STOP;
                        end else if (bus.idle_req) begin
                            state_d = PMU_IDLE;
                        end
                    end
                end
                PMU_IDLE: begin
                    if (bus.int_req) begin
                        state_d      = PMU_RUN;
                        cpu_resume_d = 1'b1;
                    end
                end
                PMU_STOP: begin
                    if (bus.int_req) begin
                        state_d      = PMU_WAKE;
                        cnt_load     = 1'b1;
                        cnt_load_val = WAKE_LOAD;
                    end
                end
                PMU_WAKE: begin
                    if (cnt_zero) begin
                        state_d      = PMU_RUN;
                        cpu_resume_d = 1'b1;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                default: begin
                    state_d  = PMU_RESET;
                    kind_d   = KIND_POR;
                    cnt_load = 1'b1;
                end
            endcase
        end
    end

    // Output decode from the state being entered, so every output is a flop
    // that changes on the same edge as the state.
    always_comb begin
        clkcpu_en_d = 1'b0;
        clkper_en_d = 1'b0;
        rst_out_d   = 1'b0;
        rsttowdt_d  = 1'b0;
        rsttosrst_d = 1'b0;
        unique case (state_d)
            PMU_RESET: begin
                clkcpu_en_d = 1'b1;
                clkper_en_d = 1'b1;
                rst_out_d   = 1'b1;
                // The watchdog is not reset by its own overflow and SRST is
                // not reset by a software request, so the cause stays visible.
                rsttowdt_d  = (kind_d != KIND_WDT);
                rsttosrst_d = (kind_d != KIND_SW);
            end
            PMU_RUN: begin
                clkcpu_en_d = 1'b1;
                clkper_en_d = 1'b1;
            end
            PMU_IDLE: begin
                clkper_en_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Setting a cause bit wins over a simultaneous clear.
    always_comb begin
        cause_d = bus.cause_clr ? 3'b000 : cause_q;
        if (bus.wdts) begin
            cause_d[CAUSE_WDT] = 1'b1;
        end
        if (bus.srst) begin
            cause_d[CAUSE_SW] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= PMU_RESET;
            kind_q       <= KIND_POR;
            cause_q      <= 3'b001;
            clkcpu_en_q  <= 1'b0;
            clkper_en_q  <= 1'b0;
            cpu_resume_q <= 1'b0;
            rst_out_q    <= 1'b1;
            rsttowdt_q   <= 1'b1;
            rsttosrst_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            cause_q      <= cause_d;
            clkcpu_en_q  <= clkcpu_en_d;
            clkper_en_q  <= clkper_en_d;
            cpu_resume_q <= cpu_resume_d;
            rst_out_q    <= rst_out_d;
            rsttowdt_q   <= rsttowdt_d;
            rsttosrst_q  <= rsttosrst_d;
        end
    end

    assign bus.clkcpu_en  = clkcpu_en_q;
    assign bus.clkper_en  = clkper_en_q;
    assign bus.cpu_resume = cpu_resume_q;
    assign bus.rst_out    = rst_out_q;
    assign bus.rsttowdt   = rsttowdt_q;
    assign bus.rsttosrst  = rsttosrst_q;
    assign bus.pmu_state  = state_q;
    assign bus.rst_cause  = cause_q;

endmodule

// File: tb/tb_pmu_sequencer.sv
module tb_pmu_sequencer;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    pmu_sequencer_if bus_if ();

    pmu_sequencer #(
        .RST_HOLD (16),
        .WAKE_CYC (256),
        .CNT_W    (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs are applied 1 ns after a rising edge; outputs are sampled there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles until rst_out drops, starting with one cycle already seen.
    task automatic rst_width(output int n);
        n = 1;
        tick();
        while (bus_if.rst_out && n < 200) begin
            n++;
            tick();
        end
    endtask

    // Counts cycles spent in WAKE (already in WAKE on entry) and flags any
    // cycle where a clock enable leaked on.
    task automatic wake_width(output int n, output int bad_en);
        n      = 1;
        bad_en = 0;
        while (bus_if.pmu_state == 3'd4 && n < 1000) begin
            if (bus_if.clkcpu_en || bus_if.clkper_en) bad_en++;
            tick();
            if (bus_if.pmu_state == 3'd4) n++;
        end
    endtask

    task automatic pulse_idle();
        bus_if.idle_req = 1'b1;
        tick();
        bus_if.idle_req = 1'b0;
    endtask

    task automatic pulse_int();
        bus_if.int_req = 1'b1;
        tick();
        bus_if.int_req = 1'b0;
    endtask

    initial begin
        int n;
        int bad;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus_if.wdts      = 1'b0;
        bus_if.srst      = 1'b0;
        bus_if.idle_req  = 1'b0;
        bus_if.stop_req  = 1'b0;
        bus_if.int_req   = 1'b0;
        bus_if.cause_clr = 1'b0;
        tick();
        tick();
        chk("por_state", bus_if.pmu_state, 0);
        chk("por_rst_out", bus_if.rst_out, 1);
        chk("por_rsttowdt", bus_if.rsttowdt, 1);
        chk("por_rsttosrst", bus_if.rsttosrst, 1);
        chk("por_clkcpu", bus_if.clkcpu_en, 0);
        chk("por_cause", bus_if.rst_cause, 3'b001);
        rst = 1'b0;

        // POR stretch: 16 cycles of rst_out after release.
        n = 0;
        tick();
        n = 1;
        chk("por_en_in_reset", bus_if.clkcpu_en, 1);
        while (bus_if.rst_out && n < 200) begin
            n++;
            tick();
        end
        chk("por_width", n, 16);
        chk("por_run_state", bus_if.pmu_state, 1);
        chk("por_run_clkcpu", bus_if.clkcpu_en, 1);
        chk("por_run_clkper", bus_if.clkper_en, 1);
        chk("por_run_cause", bus_if.rst_cause, 3'b001);

        // Idle entry and resume.
        pulse_idle();
        chk("idle_state", bus_if.pmu_state, 2);
        chk("idle_clkcpu", bus_if.clkcpu_en, 0);
        chk("idle_clkper", bus_if.clkper_en, 1);
        tick();
        tick();
        chk("idle_hold", bus_if.pmu_state, 2);
        pulse_int();
        chk("idle_exit_state", bus_if.pmu_state, 1);
        chk("idle_resume", bus_if.cpu_resume, 1);
        chk("idle_exit_clkcpu", bus_if.clkcpu_en, 1);
        tick();
        chk("idle_resume_single", bus_if.cpu_resume, 0);

        // Stop, requests ignored in STOP, then 256-cycle wake.
        bus_if.stop_req = 1'b1;
        tick();
        bus_if.stop_req = 1'b0;
        chk("stop_state", bus_if.pmu_state, 3);
        chk("stop_clkcpu", bus_if.clkcpu_en, 0);
        chk("stop_clkper", bus_if.clkper_en, 0);
        pulse_idle();
        chk("stop_ignores_idle", bus_if.pmu_state, 3);
        pulse_int();
        chk("wake_state", bus_if.pmu_state, 4);
        wake_width(n, bad);
        chk("wake_width", n, 256);
        chk("wake_enables_off", bad, 0);
        chk("wake_exit_state", bus_if.pmu_state, 1);
        chk("wake_resume", bus_if.cpu_resume, 1);
        tick();
        chk("wake_resume_single", bus_if.cpu_resume, 0);

        // Watchdog overflow while idle.
        pulse_idle();
        bus_if.wdts = 1'b1;
        tick();
        bus_if.wdts = 1'b0;
        chk("wdt_state", bus_if.pmu_state, 0);
        chk("wdt_rsttowdt", bus_if.rsttowdt, 0);
        chk("wdt_rsttosrst", bus_if.rsttosrst, 1);
        chk("wdt_cause", bus_if.rst_cause, 3'b011);
        chk("wdt_clkcpu", bus_if.clkcpu_en, 1);
        rst_width(n);
        chk("wdt_width", n, 16);
        chk("wdt_run_state", bus_if.pmu_state, 1);
        bus_if.cause_clr = 1'b1;
        tick();
        bus_if.cause_clr = 1'b0;
        chk("cause_cleared", bus_if.rst_cause, 3'b000);

        // srst held 5 cycles, then wdts+srst together for one more cycle.
        bus_if.srst = 1'b1;
        tick();
        chk("sw_rsttowdt", bus_if.rsttowdt, 1);
        chk("sw_rsttosrst", bus_if.rsttosrst, 0);
        for (int i = 0; i < 4; i++) tick();
        bus_if.wdts = 1'b1;
        tick();
        bus_if.wdts = 1'b0;
        bus_if.srst = 1'b0;
        chk("both_rsttowdt", bus_if.rsttowdt, 1);
        chk("both_rsttosrst", bus_if.rsttosrst, 1);
        chk("both_cause", bus_if.rst_cause, 3'b110);
        rst_width(n);
        chk("both_width", n, 16);

        // Set beats clear on rst_cause.
        bus_if.cause_clr = 1'b1;
        bus_if.wdts      = 1'b1;
        tick();
        bus_if.cause_clr = 1'b0;
        bus_if.wdts      = 1'b0;
        chk("cause_set_over_clr", bus_if.rst_cause, 3'b010);
        rst_width(n);
        chk("wdt2_width", n, 16);

        // Requests with int_req high are dropped; without it Stop wins.
        bus_if.idle_req = 1'b1;
        bus_if.stop_req = 1'b1;
        bus_if.int_req  = 1'b1;
        tick();
        chk("req_int_state", bus_if.pmu_state, 1);
        chk("req_int_resume", bus_if.cpu_resume, 0);
        bus_if.int_req = 1'b0;
        tick();
        bus_if.idle_req = 1'b0;
        bus_if.stop_req = 1'b0;
        chk("stop_beats_idle", bus_if.pmu_state, 3);
        chk("stop_beats_idle_clkper", bus_if.clkper_en, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
